// File: rtl/pcap_mem_replay_mq_if.sv
// pcap_mem_replay_mq_if: packed multi-queue AXI-Stream bundle, queue q occupies slice q of every field
interface pcap_mem_replay_mq_if #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES         = 4
);
    logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]   tdata;
    logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0] tkeep;
    logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]  tuser;
    logic [NUM_QUEUES-1:0]                     tlast;
    logic [NUM_QUEUES-1:0]                     tvalid;
    logic [NUM_QUEUES-1:0]                     tready;
    modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/pcap_mem_replay_mq.sv
// pcap_mem_replay_mq: per-queue FWFT FIFOs forwarding whole replay packets, dropping end-of-replay markers
module pcap_mem_replay_mq #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES         = 4,
    parameter int FIFO_DEPTH_BITS    = 6,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                            axis_aclk,
    input  logic                            axis_areset,
    input  logic                            sw_rst,
    input  logic [NUM_QUEUES-1:0]           q_en,
    input  logic                            stats_clr,
    pcap_mem_replay_mq_if.slave             s_axis,
    pcap_mem_replay_mq_if.master            m_axis,
    output logic [NUM_QUEUES-1:0]           replay_done,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0] pkt_cnt
);
    localparam int DW    = C_AXIS_DATA_WIDTH;
    localparam int KW    = DW / 8;
    localparam int UW    = C_AXIS_TUSER_WIDTH;
    localparam int EW    = 1 + UW + KW + DW;
    localparam int AW    = FIFO_DEPTH_BITS;
    localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;

    typedef enum logic [1:0] {IDLE, SEND, ABORT, FLUSH} state_t;

    state_t               state_q  [NUM_QUEUES];
    state_t               state_d  [NUM_QUEUES];
    logic [EW-1:0]        mem_q    [NUM_QUEUES][DEPTH];
    logic [EW-1:0]        head     [NUM_QUEUES];
    logic [AW-1:0]        wr_ptr_q [NUM_QUEUES];
    logic [AW-1:0]        rd_ptr_q [NUM_QUEUES];
    logic [AW:0]          occ_q    [NUM_QUEUES];
    logic [CNT_WIDTH-1:0] cnt_q    [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] push, pop, inc, empty, marker;

    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            head[q] = mem_q[q][rd_ptr_q[q]];
        end
    end

    // entry layout is {tlast, tuser, tkeep, tdata}
    always_comb begin
        m_axis.tdata  = '0;
        m_axis.tkeep  = '0;
        m_axis.tuser  = '0;
        m_axis.tlast  = '0;
        s_axis.tready = '0;
        pkt_cnt       = '0;
        push          = '0;
        empty         = '0;
        marker        = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            m_axis.tdata[q*DW +: DW] = head[q][DW-1:0];
            m_axis.tkeep[q*KW +: KW] = head[q][DW +: KW];
            m_axis.tuser[q*UW +: UW] = head[q][DW+KW +: UW];
            m_axis.tlast[q]          = head[q][EW-1];
            s_axis.tready[q]         = occ_q[q] != (AW+1)'(DEPTH);
            push[q]                  = s_axis.tvalid[q] && occ_q[q] != (AW+1)'(DEPTH);
            empty[q]                 = occ_q[q] == '0;
            marker[q]                = occ_q[q] != '0 && head[q][EW-1] && head[q][DW +: KW] == '0;
            pkt_cnt[q*CNT_WIDTH +: CNT_WIDTH] = cnt_q[q];
        end
    end

    always_comb begin
        m_axis.tvalid = '0;
        replay_done   = '0;
        pop           = '0;
        inc           = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            state_d[q] = state_q[q];
            case (state_q[q])
                IDLE: begin
                    if (sw_rst) begin
                        state_d[q] = FLUSH;
                    end else if (marker[q]) begin
                        pop[q]         = 1'b1;
                        replay_done[q] = 1'b1;
                    end else if (q_en[q] && !empty[q]) begin
                        m_axis.tvalid[q] = 1'b1;
                        pop[q]           = m_axis.tready[q];
                        inc[q]           = m_axis.tready[q] && head[q][EW-1];
                        if (m_axis.tready[q] && !head[q][EW-1]) state_d[q] = SEND;
                    end
                end
                SEND, ABORT: begin
                    // the head only moves on a handshake, so a presented beat stays stable
                    m_axis.tvalid[q] = !empty[q];
                    pop[q]           = !empty[q] && m_axis.tready[q];
                    inc[q]           = !empty[q] && m_axis.tready[q] && head[q][EW-1];
                    if (inc[q]) state_d[q] = (sw_rst || state_q[q] == ABORT) ? FLUSH : IDLE;
                    else if (sw_rst) state_d[q] = ABORT;
                end
                default: begin
                    pop[q] = !empty[q];
                    if (empty[q] && !sw_rst) state_d[q] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge axis_aclk) begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (push[q]) mem_q[q][wr_ptr_q[q]] <= {s_axis.tlast[q], s_axis.tuser[q*UW +: UW],
                                                   s_axis.tkeep[q*KW +: KW], s_axis.tdata[q*DW +: DW]};
        end
    end

    always_ff @(posedge axis_aclk) begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (axis_areset) begin
                state_q[q]  <= IDLE;
                wr_ptr_q[q] <= '0;
                rd_ptr_q[q] <= '0;
                occ_q[q]    <= '0;
                cnt_q[q]    <= '0;
            end else begin
                state_q[q]  <= state_d[q];
                wr_ptr_q[q] <= wr_ptr_q[q] + AW'(push[q]);
                rd_ptr_q[q] <= rd_ptr_q[q] + AW'(pop[q]);
                occ_q[q]    <= occ_q[q] + (AW+1)'(push[q]) - (AW+1)'(pop[q]);
                cnt_q[q]    <= stats_clr ? '0 : cnt_q[q] + CNT_WIDTH'(inc[q]);
            end
        end
    end
endmodule

// File: doc/pcap_mem_replay_mq.md
Name: pcap_mem_replay_mq

Overview:
- Parametrised multi-queue replay drain stage between the external-memory PCAP loader and the per-port output pipeline.
- Each queue buffers AXI-Stream beats in a first-word-fall-through FIFO and forwards whole packets to its master port.
- Each queue drops in-band end-of-replay marker beats and signals completion.
- Adds over the previous generation: N queues on packed buses, configurable depth, per-queue enable gating at packet boundaries, graceful sw_rst abort, tlast carried through, per-queue packet counters.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width; tkeep is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, tuser width.
- NUM_QUEUES, 4, number of independent queues (1..16).
- FIFO_DEPTH_BITS, 6, per-queue FIFO depth is 2**FIFO_DEPTH_BITS beats.
- CNT_WIDTH, 32, per-queue packet counter width.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_areset  in  1  synchronous, active-high reset.
- sw_rst  in  1  software abort request, level, common to all queues.
- q_en  in  NUM_QUEUES  per-queue enable; sampled only at packet boundaries.
- stats_clr  in  1  one-cycle pulse; clears all packet counters.
- s_axis_tdata  in  NUM_QUEUES*C_AXIS_DATA_WIDTH  slave data; queue q occupies slice q.
- s_axis_tkeep  in  NUM_QUEUES*C_AXIS_DATA_WIDTH/8  slave byte enables.
- s_axis_tuser  in  NUM_QUEUES*C_AXIS_TUSER_WIDTH  slave sideband.
- s_axis_tlast  in  NUM_QUEUES  slave end of packet.
- s_axis_tvalid  in  NUM_QUEUES  slave valid.
- s_axis_tready  out  NUM_QUEUES  slave ready.
- m_axis_tdata  out  NUM_QUEUES*C_AXIS_DATA_WIDTH  master data.
- m_axis_tkeep  out  NUM_QUEUES*C_AXIS_DATA_WIDTH/8  master byte enables.
- m_axis_tuser  out  NUM_QUEUES*C_AXIS_TUSER_WIDTH  master sideband.
- m_axis_tlast  out  NUM_QUEUES  master end of packet.
- m_axis_tvalid  out  NUM_QUEUES  master valid.
- m_axis_tready  in  NUM_QUEUES  master ready.
- replay_done  out  NUM_QUEUES  one-cycle pulse per marker consumed.
- pkt_cnt  out  NUM_QUEUES*CNT_WIDTH  packets forwarded per queue.

Behaviour:
- Reset:
  - All FIFOs empty and all queue states IDLE.
  - m_axis_tvalid=0, replay_done=0, pkt_cnt=0.
  - s_axis_tready=1 from the first cycle after reset release.
- FIFO storage and acceptance:
  - Each entry stores {tlast,tuser,tkeep,tdata}.
  - s_axis_tready[q] = (occupancy[q] != 2**FIFO_DEPTH_BITS), computed from a registered occupancy.
  - Write when tvalid & tready.
  - A beat written in cycle N is visible at the FIFO head in cycle N+1.
  - Simultaneous push and pop leaves occupancy unchanged.
- Master outputs: m_axis_tdata/tkeep/tuser/tlast always equal the FIFO head. Pop happens only on m_tvalid&m_tready or on a discard.
- Marker definition: a head beat with tlast=1 and tkeep=0 while the queue is in IDLE.
- Queue FSM (independent per queue):
  - IDLE (packet boundary):
    - sw_rst=1 -> FLUSH.
    - Else if head is a marker: discard it (pop, tvalid=0), pulse replay_done, stay IDLE.
    - Else if q_en & ~empty: tvalid=1. On handshake, a beat with tlast=1 increments pkt_cnt and stays in IDLE; a beat with tlast=0 -> SEND.
    - Else tvalid=0.
  - SEND (mid-packet):
    - tvalid = ~empty, independent of q_en and of tready.
    - Handshake of a tlast beat increments pkt_cnt; next state is FLUSH if sw_rst=1, else IDLE.
    - sw_rst=1 without a tlast handshake -> ABORT.
  - ABORT: behaves as SEND, but exits to FLUSH on the tlast handshake. The packet is never truncated on the wire.
  - FLUSH:
    - tvalid=0; pop every cycle while ~empty. Discarded beats, markers included, give no replay_done and no pkt_cnt change.
    - Exit to IDLE when empty=1 and sw_rst=0.
    - s_axis_tready keeps normal semantics, so upstream still drains.
- AXIS rule: once tvalid=1 in SEND/ABORT, tvalid and the head beat stay stable until tready. This holds because a pop occurs only on handshake.
- Counter:
  - pkt_cnt wraps modulo 2**CNT_WIDTH.
  - stats_clr sets it to 0. If an increment falls in the same cycle, the counter ends at 0; clear wins.
- axis_areset mid-packet: immediate return to the reset state. Partial FIFO contents are lost and no tlast is emitted.

Test Plan:
- Queue 0, q_en=1, tready=1; push a 3-beat packet then a marker (tlast=1, tkeep=0) -> 3 beats out on back-to-back cycles with tlast on the 3rd; pkt_cnt[0]=1; one replay_done[0] pulse; marker never appears on m_axis.
- Fill queue 1 with 64 beats while tready=0 (FIFO_DEPTH_BITS=6) -> s_axis_tready[1]=0 after 64 accepted beats. Raise tready -> beats drain in order and tready returns to 1 the cycle after the first pop.
- Pulse sw_rst during beat 2 of a 4-beat packet, with 2 more packets queued -> beats 2..4 still emitted ending in tlast; queued packets discarded with no m_tvalid; pkt_cnt +1 only; IDLE once empty and sw_rst=0.
- q_en[2] deasserted mid-packet -> current packet completes; the next packet is held with tvalid=0 until q_en[2]=1.
- All 4 queues active with random tready -> per-queue ordering preserved and no cross-queue interference. stats_clr coincident with a tlast handshake -> pkt_cnt=0.
- axis_areset asserted mid-packet -> next cycle tvalid=0, pkt_cnt=0, tready=1.
